pika_game_ctrl: RTL and testbench



---
 rtl/pika_game_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_pika_game_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pika_game_ctrl.sv
// Match sequencer for PikaBall: START -> WAIT (serve hold) -> IN_GAME (landing watch) -> END.
// Optional start-button synchronizer is enabled by defining PIKA_BTN_SYNC_EN.
module pika_game_ctrl #(
  parameter int WIN_SCORE   = 5,
  parameter int SERVE_DELAY = 50_000_000,
  parameter int FLOOR_Y     = 220,
  parameter int NET_X       = 160,
  parameter int NET_W       = 6,
  parameter int BALL_W      = 30,
  parameter int BALL_H      = 30,
  parameter int GUARD       = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_btn,
  input  logic [11:0] Ball_X,
  input  logic [11:0] Ball_Y,
  output logic [1:0]  Game_state,
  output logic        who_win,
  output logic [3:0]  Player_score,
  output logic [3:0]  NPC_score,
  output logic        point_pulse
);

  typedef enum logic [1:0] {
    ST_START   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_IN_GAME = 2'd2,
    ST_END     = 2'd3
  } state_t;

  localparam int SERVE_W = (SERVE_DELAY > 2) ? $clog2(SERVE_DELAY) : 1;
  localparam int GUARD_W = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

  localparam logic [SERVE_W-1:0] SERVE_LAST = SERVE_W'(SERVE_DELAY - 1);
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD);
  localparam logic [12:0]        FLOOR_13   = 13'(FLOOR_Y);
  localparam logic [12:0]        BALL_H_13  = 13'(BALL_H);
  localparam logic [12:0]        HALF_W_13  = 13'(BALL_W / 2);
  localparam logic [12:0]        NET_MID_13 = 13'(NET_X + NET_W / 2);
  localparam logic [3:0]         WIN_4      = 4'(WIN_SCORE);

  state_t             state_r, state_nxt_s;
  logic [SERVE_W-1:0] serve_cnt_r, serve_cnt_nxt_s;
  logic [GUARD_W-1:0] guard_cnt_r, guard_cnt_nxt_s;
  logic [3:0]         player_score_r, player_score_nxt_s;
  logic [3:0]         npc_score_r, npc_score_nxt_s;
  logic               who_win_r, who_win_nxt_s;
  logic               point_pulse_r, point_pulse_nxt_s;

  logic               btn_s;
  logic               btn_prev_r;
  logic               start_edge_s;
  logic [12:0]        bottom_s;
  logic [12:0]        cx_s;
  logic               landed_s;
  logic               npc_side_s;
  logic [3:0]         player_inc_s;
  logic [3:0]         npc_inc_s;

`ifdef PIKA_BTN_SYNC_EN
  logic btn_meta_r;
  logic btn_sync_r;

  // Two-flop synchronizer for the asynchronous button
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta_r <= 1'b0;
      btn_sync_r <= 1'b0;
    end else begin
      btn_meta_r <= start_btn;
      btn_sync_r <= btn_meta_r;
    end
  end

  assign btn_s = btn_sync_r;
`else
  assign btn_s = start_btn;
`endif

  // Button history for rising-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_prev_r <= 1'b0;
    end else begin
      btn_prev_r <= btn_s;
    end
  end

  assign start_edge_s = btn_s & ~btn_prev_r;

  // 13-bit sums cannot wrap for any 12-bit coordinate
  assign bottom_s   = {1'b0, Ball_Y} + BALL_H_13;
  assign cx_s       = {1'b0, Ball_X} + HALF_W_13;
  assign landed_s   = (bottom_s >= FLOOR_13) && (guard_cnt_r == GUARD_LAST);
  assign npc_side_s = (cx_s < NET_MID_13);

  assign player_inc_s = (player_score_r < WIN_4) ? (player_score_r + 4'd1) : player_score_r;
  assign npc_inc_s    = (npc_score_r < WIN_4) ? (npc_score_r + 4'd1) : npc_score_r;

  // Next-state, counter and score logic
  always_comb begin
    state_nxt_s        = state_r;
    serve_cnt_nxt_s    = serve_cnt_r;
    guard_cnt_nxt_s    = guard_cnt_r;
    player_score_nxt_s = player_score_r;
    npc_score_nxt_s    = npc_score_r;
    who_win_nxt_s      = who_win_r;
    point_pulse_nxt_s  = 1'b0;

    case (state_r)
      ST_START: begin
        if (start_edge_s) begin
          player_score_nxt_s = 4'd0;
          npc_score_nxt_s    = 4'd0;
          who_win_nxt_s      = 1'b0;
          serve_cnt_nxt_s    = {SERVE_W{1'b0}};
          state_nxt_s        = ST_WAIT;
        end else begin
          state_nxt_s = ST_START;
        end
      end

      ST_WAIT: begin
        if (serve_cnt_r == SERVE_LAST) begin
          serve_cnt_nxt_s = {SERVE_W{1'b0}};
          guard_cnt_nxt_s = {GUARD_W{1'b0}};
          state_nxt_s     = ST_IN_GAME;
        end else begin
          serve_cnt_nxt_s = serve_cnt_r + {{(SERVE_W-1){1'b0}}, 1'b1};
        end
      end

      ST_IN_GAME: begin
        if (landed_s) begin
          point_pulse_nxt_s = 1'b1;
          serve_cnt_nxt_s   = {SERVE_W{1'b0}};
          if (npc_side_s) begin
            player_score_nxt_s = player_inc_s;
            who_win_nxt_s      = 1'b0;
            state_nxt_s        = (player_inc_s == WIN_4) ? ST_END : ST_WAIT;
          end else begin
            npc_score_nxt_s = npc_inc_s;
            who_win_nxt_s   = 1'b1;
            state_nxt_s     = (npc_inc_s == WIN_4) ? ST_END : ST_WAIT;
          end
        end else if (guard_cnt_r != GUARD_LAST) begin
          guard_cnt_nxt_s = guard_cnt_r + {{(GUARD_W-1){1'b0}}, 1'b1};
        end else begin
          guard_cnt_nxt_s = guard_cnt_r;
        end
      end

      ST_END: begin
        if (start_edge_s) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_END;
        end
      end

      default: begin
        state_nxt_s = ST_START;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= ST_START;
      serve_cnt_r    <= {SERVE_W{1'b0}};
      guard_cnt_r    <= {GUARD_W{1'b0}};
      player_score_r <= 4'd0;
      npc_score_r    <= 4'd0;
      who_win_r      <= 1'b0;
      point_pulse_r  <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      serve_cnt_r    <= serve_cnt_nxt_s;
      guard_cnt_r    <= guard_cnt_nxt_s;
      player_score_r <= player_score_nxt_s;
      npc_score_r    <= npc_score_nxt_s;
      who_win_r      <= who_win_nxt_s;
      point_pulse_r  <= point_pulse_nxt_s;
    end
  end

  assign Game_state   = state_r;
  assign who_win      = who_win_r;
  assign Player_score = player_score_r;
  assign NPC_score    = npc_score_r;
  assign point_pulse  = point_pulse_r;

endmodule

// File: tb/tb_pika_game_ctrl.sv
// Self-checking bench for pika_game_ctrl: rule-level match model compared every cycle,
// plus directed literal checks; honours PIKA_BTN_SYNC_EN for start latency.
module tb_pika_game_ctrl;

  localparam int SD    = 4;
  localparam int WIN   = 5;
  localparam int GUARD = 2;
`ifdef PIKA_BTN_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_btn = 1'b0;
  logic [11:0] Ball_X = 12'd20;
  logic [11:0] Ball_Y = 12'd0;
  logic [1:0]  Game_state;
  logic        who_win;
  logic [3:0]  Player_score;
  logic [3:0]  NPC_score;
  logic        point_pulse;

  int n_total = 0;
  int n_pass  = 0;

  pika_game_ctrl #(.WIN_SCORE(WIN), .SERVE_DELAY(SD), .GUARD(GUARD)) dut (
    .clk(clk), .reset_n(reset_n), .start_btn(start_btn),
    .Ball_X(Ball_X), .Ball_Y(Ball_Y),
    .Game_state(Game_state), .who_win(who_win),
    .Player_score(Player_score), .NPC_score(NPC_score),
    .point_pulse(point_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Match model: time spent in the current phase, scores, and button samples
  int m_st = 0, m_age = 0, m_ps = 0, m_ns = 0, m_who = 0, m_pulse = 0;
  int hist [0:3] = '{0, 0, 0, 0};

  always @(posedge clk or negedge reset_n) begin : model
    int  cx;
    bit  press, land, won;
    if (!reset_n) begin
      m_st = 0; m_age = 0; m_ps = 0; m_ns = 0; m_who = 0; m_pulse = 0;
      for (int i = 0; i < 4; i++) hist[i] = 0;
    end else begin
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = int'(start_btn);
      press   = (hist[LAT] == 1) && (hist[LAT+1] == 0);
      m_pulse = 0;
      won     = 1'b0;
      case (m_st)
        0: if (press) begin
             m_ps = 0; m_ns = 0; m_who = 0; m_st = 1; m_age = 0;
           end
        1: if (m_age == SD - 1) begin m_st = 2; m_age = 0; end
           else m_age++;
        2: begin
             land = (int'(Ball_Y) + 30 >= 220) && (m_age >= GUARD);
             if (land) begin
               cx = int'(Ball_X) + 15;
               if (cx < 163) begin m_ps++; m_who = 0; won = (m_ps == WIN); end
               else          begin m_ns++; m_who = 1; won = (m_ns == WIN); end
               m_pulse = 1;
               m_st    = won ? 3 : 1;
               m_age   = 0;
             end else begin
               m_age++;
             end
           end
        3: if (press) m_st = 0;
        default: m_st = 0;
      endcase
    end
  end

  // Cycle-by-cycle comparison away from the active edge
  always @(negedge clk) begin
    if (reset_n) begin
      chk("cyc_state",  int'(Game_state),   m_st);
      chk("cyc_who",    int'(who_win),      m_who);
      chk("cyc_player", int'(Player_score), m_ps);
      chk("cyc_npc",    int'(NPC_score),    m_ns);
      chk("cyc_pulse",  int'(point_pulse),  m_pulse);
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_in_game(input string tag);
    for (int i = 0; i < 20 && Game_state != 2'd2; i++) tick(1);
    chk({tag, "_in_game"}, int'(Game_state), 2);
  endtask

  // Land the ball once guard has expired; award lands on the third edge
  task automatic rally(input int x, input int y, input string tag);
    wait_in_game(tag);
    Ball_X = 12'(x);
    Ball_Y = 12'(y);
    tick(3);
    Ball_X = 12'd20;
    Ball_Y = 12'd0;
  endtask

  initial begin
    tick(3);
    chk("rst_state",  int'(Game_state),   0);
    chk("rst_player", int'(Player_score), 0);
    chk("rst_pulse",  int'(point_pulse),  0);
    reset_n = 1'b1;
    tick(1);

    // Start: state moves exactly LAT+1 edges after the press
    start_btn = 1'b1;
    tick(LAT);
    chk("start_latency_hold", int'(Game_state), 0);
    tick(1);
    chk("start_to_wait", int'(Game_state), 1);
    chk("start_scores",  int'(Player_score) + int'(NPC_score), 0);
    tick(SD - 1);
    chk("wait_len_hold", int'(Game_state), 1);
    tick(1);
    chk("wait_to_game", int'(Game_state), 2);

    // Landing from the first IN_GAME cycle is masked by the guard
    Ball_X = 12'd20;
    Ball_Y = 12'd190;
    tick(2);
    chk("guard_state",  int'(Game_state),   2);
    chk("guard_player", int'(Player_score), 0);
    tick(1);
    chk("land_player", int'(Player_score), 1);
    chk("land_who",    int'(who_win),      0);
    chk("land_pulse",  int'(point_pulse),  1);
    chk("land_state",  int'(Game_state),   1);
    Ball_Y = 12'd0;
    tick(1);
    chk("pulse_drop",  int'(point_pulse),  0);
    chk("once_player", int'(Player_score), 1);

    rally(140, 190, "x140");
    chk("x140_player", int'(Player_score), 2);
    rally(134, 190, "x134");
    chk("x134_player", int'(Player_score), 3);
    rally(148, 190, "x148");
    chk("x148_npc", int'(NPC_score), 1);
    chk("x148_who", int'(who_win),   1);
    rally(148, 190, "x148b");
    chk("pre_rst_npc",   int'(NPC_score), 2);
    chk("model_pin_ps",  m_ps, 3);

    // Asynchronous reset mid-WAIT
    tick(1);
    chk("pre_rst_state", int'(Game_state), 1);
    start_btn = 1'b0;
    reset_n   = 1'b0;
    #1;
    chk("arst_state",  int'(Game_state),   0);
    chk("arst_player", int'(Player_score), 0);
    chk("arst_npc",    int'(NPC_score),    0);
    chk("arst_who",    int'(who_win),      0);
    chk("arst_pulse",  int'(point_pulse),  0);
    tick(2);
    reset_n = 1'b1;
    tick(1);

    start_btn = 1'b1;
    tick(LAT + 1);
    chk("restart_state", int'(Game_state), 1);
    start_btn = 1'b0;

    // NPC rally with a just-short landing first (189+30 = 219)
    wait_in_game("npc1");
    Ball_X = 12'd200;
    Ball_Y = 12'd189;
    tick(4);
    chk("near_floor_state", int'(Game_state), 2);
    chk("near_floor_npc",   int'(NPC_score),  0);
    Ball_Y = 12'd190;
    tick(1);
    chk("npc1_score", int'(NPC_score),   1);
    chk("npc1_pulse", int'(point_pulse), 1);
    Ball_Y = 12'd0;
    for (int k = 2; k <= WIN; k++) begin
      rally(200, 190, "npc");
      chk("npc_score", int'(NPC_score), k);
    end
    chk("end_state", int'(Game_state), 3);
    chk("end_who",   int'(who_win),    1);

    // Landings in END are ignored
    Ball_X = 12'd200;
    Ball_Y = 12'd190;
    tick(5);
    chk("end_ignore_state", int'(Game_state), 3);
    chk("end_ignore_npc",   int'(NPC_score),  5);
    Ball_Y = 12'd0;

    start_btn = 1'b1;
    tick(LAT);
    chk("end_latency_hold", int'(Game_state), 3);
    tick(1);
    chk("end_to_start", int'(Game_state), 0);
    chk("start_hold_npc", int'(NPC_score), 5);
    tick(5);
    chk("held_btn_state", int'(Game_state), 0);
    start_btn = 1'b0;
    tick(1);
    start_btn = 1'b1;
    tick(LAT);
    chk("second_latency_hold", int'(Game_state), 0);
    tick(1);
    chk("second_state",  int'(Game_state),   1);
    chk("second_npc",    int'(NPC_score),    0);
    chk("second_player", int'(Player_score), 0);
    start_btn = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
